mem_slot_sched: RTL and testbench

- Memory-slot scheduler that shares the single RAM/ROM data port between five requesters: CPU, video fetch, sound fetch, internal disk DMA and external disk DMA.
- Sits beside the data controller. It drives videoBusControl, cpuBusControl and memoryLatch, which the data controller and video shifter consume.
- Time-slices the bus into fixed 4-tick frames of the 8 MHz enable. Each requester gets one grant and one acknowledge pulse per access.

---
 rtl/mem_slot_pkg.sv | 32 +++
 rtl/mem_slot_sched_if.sv | 32 +++
 rtl/mem_slot_prio.sv | 39 +++
 rtl/mem_slot_sched.sv | 116 +++++++++++
 tb/tb_mem_slot_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_slot_pkg.sv
// Shared encodings for the memory-slot scheduler: grant codes, FSM states, slot ticks.
package mem_slot_pkg;

    typedef logic [2:0] grant_t;

    localparam grant_t GNT_IDLE = 3'd0;
    localparam grant_t GNT_CPU  = 3'd1;
    localparam grant_t GNT_VID  = 3'd2;
    localparam grant_t GNT_SND  = 3'd3;
    localparam grant_t GNT_DSKI = 3'd4;
    localparam grant_t GNT_DSKE = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd2;

    // One-hot {dske, dski, snd, vid, cpu} for a grant code; zero for idle.
    function automatic logic [4:0] gntMask(grant_t g);
        logic [4:0] m;
        m = '0;
        if (g >= GNT_CPU && g <= GNT_DSKE) begin
            m[g - 3'd1] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_slot_sched_if.sv
// Request/acknowledge bundle between the requesters and the memory-slot scheduler.
interface mem_slot_sched_if #(
    parameter int unsigned VMISS_W = 8
);
    logic               cpuReq;
    logic               vidReq;
    logic               sndReq;
    logic               dskReqInt;
    logic               dskReqExt;
    logic [2:0]         grant;
    logic               cpuBusControl;
    logic               videoBusControl;
    logic               memoryLatch;
    logic               cpuAck;
    logic               vidAck;
    logic               sndAck;
    logic               dskReadAckInt;
    logic               dskReadAckExt;
    logic [VMISS_W-1:0] vidMiss;

    modport master (
        output cpuReq, vidReq, sndReq, dskReqInt, dskReqExt,
        input  grant, cpuBusControl, videoBusControl, memoryLatch,
        input  cpuAck, vidAck, sndAck, dskReadAckInt, dskReadAckExt, vidMiss
    );

    modport slave (
        input  cpuReq, vidReq, sndReq, dskReqInt, dskReqExt,
        output grant, cpuBusControl, videoBusControl, memoryLatch,
        output cpuAck, vidAck, sndAck, dskReadAckInt, dskReadAckExt, vidMiss
    );
endinterface

// File: rtl/mem_slot_prio.sv
// Combinational slot-priority picker. MEM_SLOT_DSK_RR_EN makes the two disks share
// one level with round-robin.
module mem_slot_prio
    import mem_slot_pkg::*;
(
    input  logic [3:0] pend,        // {dske, dski, snd, vid}
    input  logic       cpuReq,
    input  logic       slotB,
`ifdef MEM_SLOT_DSK_RR_EN
    input  logic       dskLastInt,
`endif
    output grant_t     winner
);
    logic dskIntWins;

    always_comb begin
`ifdef MEM_SLOT_DSK_RR_EN
        // With both drives waiting, the one not served last goes first.
        dskIntWins = pend[2] && !(pend[3] && dskLastInt);
`else
        dskIntWins = pend[2];
`endif
        winner = GNT_IDLE;
        if (slotB && cpuReq) begin
            winner = GNT_CPU;
        end else if (pend[0]) begin
            winner = GNT_VID;
        end else if (pend[1]) begin
            winner = GNT_SND;
        end else if (dskIntWins) begin
            winner = GNT_DSKI;
        end else if (pend[3]) begin
            winner = GNT_DSKE;
        end else if (cpuReq) begin
            winner = GNT_CPU;
        end
    end

endmodule

// File: rtl/mem_slot_sched.sv
// Shares the RAM/ROM data port between CPU, video, sound and two disk DMAs in 2-tick slots.
// MEM_SLOT_DSK_RR_EN enables round-robin between the internal and external disk.
module mem_slot_sched
    import mem_slot_pkg::*;
#(
    parameter int unsigned VMISS_W = 8
) (
    input logic             clk32,
    input logic             _reset,
    input logic             clk8_en_p,
    mem_slot_sched_if.slave bus
);
    logic [1:0]         tickQ;
    state_t             stateQ, stateD;
    grant_t             grantQ, grantD, nextGrantQ, winner;
    logic [3:0]         pendQ, pendD;   // {dske, dski, snd, vid}
    logic [4:0]         ackQ;           // {dske, dski, snd, vid, cpu}
    logic               latchQ;
    logic               cpuBusQ, vidBusQ;
    logic [VMISS_W-1:0] vidMissQ;
    logic [4:0]         busyMask;
    logic               arbTick, completing;

    assign arbTick    = clk8_en_p && (tickQ == SLOT_A || tickQ == SLOT_B);
    assign completing = clk8_en_p && (stateQ == ST_DATA);

    // The requester being finished or acked must not win the slot that follows it.
    assign busyMask = ((stateQ == ST_DATA) ? gntMask(grantQ) : 5'd0) | ackQ;

`ifdef MEM_SLOT_DSK_RR_EN
    logic dskLastIntQ;

    always_ff @(posedge clk32 or negedge _reset) begin
        if (!_reset) begin
            dskLastIntQ <= 1'b0;
        end else if (ackQ[3]) begin
            dskLastIntQ <= 1'b1;
        end else if (ackQ[4]) begin
            dskLastIntQ <= 1'b0;
        end
    end
`endif

    mem_slot_prio uPrio (
        .pend       (pendQ & ~busyMask[4:1]),
        .cpuReq     (bus.cpuReq & ~busyMask[0]),
        .slotB      (tickQ == SLOT_B),
`ifdef MEM_SLOT_DSK_RR_EN
        .dskLastInt (dskLastIntQ),
`endif
        .winner     (winner)
    );

    always_comb begin
        pendD = (pendQ & ~ackQ[4:1])
              | {bus.dskReqExt, bus.dskReqInt, bus.sndReq, bus.vidReq};

        stateD = stateQ;
        unique case (stateQ)
            ST_IDLE: if (arbTick && winner != GNT_IDLE) stateD = ST_ADDR;
            ST_ADDR: if (clk8_en_p) stateD = ST_DATA;
            ST_DATA: if (clk8_en_p) stateD = (arbTick && winner != GNT_IDLE) ? ST_ADDR : ST_IDLE;
            default: stateD = ST_IDLE;
        endcase

        // Grant hands over only after the ack cycle of the previous owner.
        grantD = grantQ;
        if (latchQ) grantD = nextGrantQ;
        if (stateQ == ST_IDLE && arbTick) grantD = winner;
    end

    always_ff @(posedge clk32 or negedge _reset) begin
        if (!_reset) begin
            tickQ      <= 2'd0;
            stateQ     <= ST_IDLE;
            grantQ     <= GNT_IDLE;
            nextGrantQ <= GNT_IDLE;
            pendQ      <= 4'd0;
            ackQ       <= 5'd0;
            latchQ     <= 1'b0;
            cpuBusQ    <= 1'b0;
            vidBusQ    <= 1'b0;
            vidMissQ   <= '0;
        end else begin
            if (clk8_en_p) tickQ <= tickQ + 2'd1;
            stateQ  <= stateD;
            grantQ  <= grantD;
            pendQ   <= pendD;
            cpuBusQ <= (grantD == GNT_CPU);
            vidBusQ <= (grantD inside {GNT_VID, GNT_SND, GNT_DSKI, GNT_DSKE});
            if (completing) begin
                ackQ       <= gntMask(grantQ);
                latchQ     <= 1'b1;
                nextGrantQ <= arbTick ? winner : GNT_IDLE;
            end else begin
                ackQ   <= 5'd0;
                latchQ <= 1'b0;
            end
            if (bus.vidReq && pendQ[0] && !ackQ[1] && vidMissQ != '1) begin
                vidMissQ <= vidMissQ + 1'b1;
            end
        end
    end

    assign bus.grant           = grantQ;
    assign bus.cpuBusControl   = cpuBusQ;
    assign bus.videoBusControl = vidBusQ;
    assign bus.memoryLatch     = latchQ;
    assign bus.cpuAck          = ackQ[0];
    assign bus.vidAck          = ackQ[1];
    assign bus.sndAck          = ackQ[2];
    assign bus.dskReadAckInt   = ackQ[3];
    assign bus.dskReadAckExt   = ackQ[4];
    assign bus.vidMiss         = vidMissQ;

endmodule

// File: tb/tb_mem_slot_sched.sv
// Scoreboard bench for mem_slot_sched: directed requests push expected acks, a monitor checks them.
module tb_mem_slot_sched;

    typedef struct {
        int code;
        int tick;
    } exp_t;

    logic clk32;
    logic _reset;
    logic en;
    int   tbTick;
    int   vectors;
    int   misses;
    exp_t sbq[$];

    mem_slot_sched_if #(.VMISS_W(8)) bus ();

    mem_slot_sched #(.VMISS_W(8)) dut (
        .clk32     (clk32),
        ._reset    (_reset),
        .clk8_en_p (en),
        .bus       (bus)
    );

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    initial begin
        en = 1'b0;
        forever begin
            repeat (3) @(negedge clk32);
            en = 1'b1;
            @(negedge clk32);
            en = 1'b0;
        end
    end

    // Reference tick count, mirrors what the slot counter should hold.
    initial begin
        tbTick = 0;
        forever begin
            @(posedge clk32);
            if (!_reset) tbTick = 0;
            else if (en) tbTick = (tbTick + 1) % 4;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int c, input int t);
        exp_t e;
        e.code = c;
        e.tick = t;
        sbq.push_back(e);
    endtask

    // Monitor: every ack cycle pops one expectation.
    initial begin
        logic [4:0] acks;
        int         code;
        exp_t       e;
        forever begin
            @(negedge clk32);
            acks = {bus.dskReadAckExt, bus.dskReadAckInt, bus.sndAck, bus.vidAck, bus.cpuAck};
            if (acks != 5'd0 || bus.memoryLatch) begin
                code = 0;
                for (int k = 0; k < 5; k++) if (acks[k]) code = k + 1;
                chk("ack_onehot_latch", int'($countones(acks) == 1 && bus.memoryLatch), 1);
                if (sbq.size() == 0) begin
                    vectors++;
                    misses++;
                    $display("FAIL unexpected_ack: got ack code %0d, required no ack", code);
                end else begin
                    e = sbq.pop_front();
                    chk("ack_code", code, e.code);
                    chk("ack_tick", tbTick, e.tick);
                    chk("ack_grant", int'(bus.grant), e.code);
                end
            end
        end
    end

    task automatic gotoTick(input int t);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(posedge clk32);
            #1;
            if (en && tbTick == t) hit = 1'b1;
        end
        if (!hit) begin
            vectors++;
            misses++;
            $display("FAIL tick_timeout: tick %0d not reached, required within 64 cycles", t);
        end
    endtask

    task automatic strobe(input logic [3:0] s);   // {dske, dski, snd, vid}
        @(negedge clk32);
        bus.vidReq    = s[0];
        bus.sndReq    = s[1];
        bus.dskReqInt = s[2];
        bus.dskReqExt = s[3];
        @(negedge clk32);
        bus.vidReq    = 1'b0;
        bus.sndReq    = 1'b0;
        bus.dskReqInt = 1'b0;
        bus.dskReqExt = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clk32);
        @(negedge clk32);
        if (sbq.size() != 0) begin
            vectors++;
            misses++;
            $display("FAIL drain_timeout: %0d acks outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic waitCpuAck();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk32);
            if (bus.cpuAck) begin
                bus.cpuReq = 1'b0;
                hit = 1'b1;
            end
        end
        if (!hit) begin
            vectors++;
            misses++;
            bus.cpuReq = 1'b0;
            $display("FAIL cpu_ack_timeout: no cpuAck, required within 100 cycles");
        end
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        _reset  = 1'b0;
        bus.cpuReq    = 1'b0;
        bus.vidReq    = 1'b0;
        bus.sndReq    = 1'b0;
        bus.dskReqInt = 1'b0;
        bus.dskReqExt = 1'b0;
        repeat (3) @(negedge clk32);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_cpuBus", int'(bus.cpuBusControl), 0);
        chk("rst_vidBus", int'(bus.videoBusControl), 0);
        chk("rst_latch", int'(bus.memoryLatch), 0);
        chk("rst_vidMiss", int'(bus.vidMiss), 0);
        _reset = 1'b1;

        // Idle: 16 ticks without requests.
        for (int i = 1; i <= 16; i++) begin
            gotoTick(i % 4);
            chk("idle_grant", int'(bus.grant), 0);
        end
        chk("idle_vidMiss", int'(bus.vidMiss), 0);

        // CPU alone: granted at the tick-2 edge, acked after the next tick-0 edge.
        gotoTick(1);
        bus.cpuReq = 1'b1;
        pushExp(1, 1);
        gotoTick(3);
        chk("cpu_grant", int'(bus.grant), 1);
        chk("cpu_cpuBus", int'(bus.cpuBusControl), 1);
        chk("cpu_vidBus", int'(bus.videoBusControl), 0);
        waitCpuAck();
        for (int j = 0; j < 8; j++) gotoTick((2 + j) % 4);
        chk("cpu_after_grant", int'(bus.grant), 0);
        drain();

        // VID + SND with CPU: A=VID, B=CPU, A=SND.
        gotoTick(3);
        bus.cpuReq = 1'b1;
        pushExp(2, 3);
        pushExp(1, 1);
        pushExp(3, 3);
        strobe(4'b0011);
        waitCpuAck();
        drain();

        // Double video strobes: one miss each, saturating at 255.
        for (int i = 0; i < 301; i++) begin
            gotoTick(1);
            pushExp(2, 1);
            @(negedge clk32);
            strobe(4'b0001);
            strobe(4'b0001);
            drain();
            if (i == 0)   chk("vidMiss_1", int'(bus.vidMiss), 1);
            if (i == 253) chk("vidMiss_254", int'(bus.vidMiss), 254);
            if (i == 254) chk("vidMiss_255", int'(bus.vidMiss), 255);
        end
        chk("vidMiss_sat", int'(bus.vidMiss), 255);

        // Both disks together, then internal alone, then both again.
        for (int r = 0; r < 2; r++) begin
            gotoTick(3);
            pushExp(4, 3);
            pushExp(5, 1);
            strobe(4'b1100);
            drain();
        end
        gotoTick(3);
        pushExp(4, 3);
        strobe(4'b0100);
        drain();
        gotoTick(3);
`ifdef MEM_SLOT_DSK_RR_EN
        pushExp(5, 3);
        pushExp(4, 1);
`else
        pushExp(4, 3);
        pushExp(5, 1);
`endif
        strobe(4'b1100);
        drain();

        // Reset during a video DATA phase: no ack, fresh frame afterwards.
        gotoTick(3);
        strobe(4'b0001);
        gotoTick(2);
        chk("data_grant", int'(bus.grant), 2);
        chk("data_vidBus", int'(bus.videoBusControl), 1);
        @(negedge clk32);
        _reset = 1'b0;
        #1;
        chk("abort_grant", int'(bus.grant), 0);
        chk("abort_vidBus", int'(bus.videoBusControl), 0);
        chk("abort_latch", int'(bus.memoryLatch), 0);
        chk("abort_vidMiss", int'(bus.vidMiss), 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 16 && !seen; i++) begin
                @(posedge clk32);
                #1;
                if (en) seen = 1'b1;
            end
        end
        @(negedge clk32);
        _reset = 1'b1;
        pushExp(2, 3);
        strobe(4'b0001);
        chk("fresh_grant_before", int'(bus.grant), 0);
        gotoTick(1);
        chk("fresh_grant", int'(bus.grant), 2);
        drain();

        repeat (20) @(negedge clk32);
        chk("queue_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
